// File: rtl/elevator_ctrl.sv
// Elevator scheduler: consumes the latched hall/car request bitmaps, moves the
// car with a directional-sweep policy and returns one-cycle clear pulses for
// every request it services. Every output comes straight from a flop.
module elevator_ctrl #(
  parameter int FLOOR       = 6,
  parameter int FLOOR_W     = 3,
  parameter int MOVE_CYCLES = 200,
  parameter int DOOR_CYCLES = 400
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FLOOR-1:0]   req_up,
  input  logic [FLOOR-1:0]   req_down,
  input  logic [FLOOR-1:0]   req_inside,
  output logic [FLOOR-1:0]   clr_up,
  output logic [FLOOR-1:0]   clr_down,
  output logic [FLOOR-1:0]   clr_inside,
  output logic [FLOOR_W-1:0] cur_floor,
  output logic [1:0]         dir,
  output logic               moving,
  output logic               door_open
);

  localparam int MOVE_W = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
  localparam int DOOR_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

  localparam logic [MOVE_W-1:0]  MOVE_LAST = MOVE_W'(MOVE_CYCLES - 1);
  localparam logic [DOOR_W-1:0]  DOOR_LAST = DOOR_W'(DOOR_CYCLES - 1);
  localparam logic [MOVE_W-1:0]  MOVE_ONE  = MOVE_W'(1'b1);
  localparam logic [DOOR_W-1:0]  DOOR_ONE  = DOOR_W'(1'b1);
  localparam logic [FLOOR_W-1:0] FLOOR_ONE = FLOOR_W'(1'b1);
  localparam logic [FLOOR-1:0]   VEC_ONE   = FLOOR'(1'b1);

  localparam logic [1:0] DIR_NONE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    MOVE   = 2'b01,
    ARRIVE = 2'b10,
    DOOR   = 2'b11
  } ctrlState_e;

  // One-hot selector of floor f within a request bitmap.
  function automatic logic [FLOOR-1:0] floorOneHot(input logic [FLOOR_W-1:0] f);
    return VEC_ONE << f;
  endfunction

  // All floor bits strictly below floor f.
  function automatic logic [FLOOR-1:0] floorsBelow(input logic [FLOOR_W-1:0] f);
    return (VEC_ONE << f) - VEC_ONE;
  endfunction

  ctrlState_e         state_r, nextState_s;
  logic [MOVE_W-1:0]  moveCnt_r, nextMoveCnt_s;
  logic [DOOR_W-1:0]  doorCnt_r, nextDoorCnt_s;
  logic [FLOOR_W-1:0] nextFloor_s;
  logic [1:0]         nextDir_s;
  logic [FLOOR-1:0]   nextClrUp_s, nextClrDown_s, nextClrInside_s;
  logic               nextMoving_s, nextDoorOpen_s;

  logic [FLOOR-1:0]   pend_s, hereMask_s, belowMask_s, aboveMask_s;
  logic               above_s, below_s, here_s, dirUp_s, dirDown_s;
  logic               furtherAhead_s, stopHere_s, doorRetrig_s;
  logic [FLOOR-1:0]   svcUp_s, svcDown_s, svcInside_s;
  logic [FLOOR-1:0]   freshUp_s, freshDown_s, freshInside_s;

  assign pend_s      = req_up | req_down | req_inside;
  assign hereMask_s  = floorOneHot(cur_floor);
  assign belowMask_s = floorsBelow(cur_floor);
  assign aboveMask_s = ~(belowMask_s | hereMask_s);
  assign above_s     = |(pend_s & aboveMask_s);
  assign below_s     = |(pend_s & belowMask_s);
  assign here_s      = |(pend_s & hereMask_s);
  assign dirUp_s     = (dir == DIR_UP);
  assign dirDown_s   = (dir == DIR_DOWN);

  // Is anything still pending beyond this floor in the current travel direction?
  always_comb begin
    furtherAhead_s = 1'b0;
    case (dir)
      DIR_UP:   furtherAhead_s = above_s;
      DIR_DOWN: furtherAhead_s = below_s;
      default:  furtherAhead_s = 1'b0;
    endcase
  end

  // Stop decision at the floor just reached.
  assign stopHere_s = (|(req_inside & hereMask_s))
                    | (dirUp_s   & (|(req_up   & hereMask_s)))
                    | (dirDown_s & (|(req_down & hereMask_s)))
                    | (here_s & ~furtherAhead_s);

  // Requests at this floor that an open door services; the opposite hall call
  // is only taken when the sweep has nothing left ahead.
  assign svcInside_s = req_inside & hereMask_s;
  assign svcUp_s     = (!dirDown_s || !furtherAhead_s) ? (req_up & hereMask_s)   : '0;
  assign svcDown_s   = (!dirUp_s   || !furtherAhead_s) ? (req_down & hereMask_s) : '0;

  // A bit being cleared this cycle is still high on the input; it is not new.
  assign freshUp_s     = svcUp_s     & ~clr_up;
  assign freshDown_s   = svcDown_s   & ~clr_down;
  assign freshInside_s = svcInside_s & ~clr_inside;
  assign doorRetrig_s  = |(freshUp_s | freshDown_s | freshInside_s);

  // State, position, direction, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      moveCnt_r  <= '0;
      doorCnt_r  <= '0;
      cur_floor  <= '0;
      dir        <= DIR_NONE;
      moving     <= 1'b0;
      door_open  <= 1'b0;
      clr_up     <= '0;
      clr_down   <= '0;
      clr_inside <= '0;
    end else begin
      state_r    <= nextState_s;
      moveCnt_r  <= nextMoveCnt_s;
      doorCnt_r  <= nextDoorCnt_s;
      cur_floor  <= nextFloor_s;
      dir        <= nextDir_s;
      moving     <= nextMoving_s;
      door_open  <= nextDoorOpen_s;
      clr_up     <= nextClrUp_s;
      clr_down   <= nextClrDown_s;
      clr_inside <= nextClrInside_s;
    end
  end

  // Sweep scheduling: next state, direction, floor and counter values.
  always_comb begin
    nextState_s   = state_r;
    nextDir_s     = dir;
    nextFloor_s   = cur_floor;
    nextMoveCnt_s = moveCnt_r;
    nextDoorCnt_s = doorCnt_r;
    case (state_r)
      IDLE: begin
        nextMoveCnt_s = '0;
        nextDoorCnt_s = '0;
        if (here_s) begin
          nextState_s = DOOR;
        end else if (dirUp_s && above_s) begin
          nextState_s = MOVE;
        end else if (dirDown_s && below_s) begin
          nextState_s = MOVE;
        end else if (above_s) begin
          nextDir_s   = DIR_UP;
          nextState_s = MOVE;
        end else if (below_s) begin
          nextDir_s   = DIR_DOWN;
          nextState_s = MOVE;
        end else begin
          nextDir_s   = DIR_NONE;
        end
      end
      MOVE: begin
        if (moveCnt_r == MOVE_LAST) begin
          nextMoveCnt_s = '0;
          nextState_s   = ARRIVE;
          if (dirUp_s) begin
            nextFloor_s = cur_floor + FLOOR_ONE;
          end else if (dirDown_s) begin
            nextFloor_s = cur_floor - FLOOR_ONE;
          end else begin
            nextFloor_s = cur_floor;
          end
        end else begin
          nextMoveCnt_s = moveCnt_r + MOVE_ONE;
        end
      end
      ARRIVE: begin
        nextMoveCnt_s = '0;
        nextDoorCnt_s = '0;
        if (stopHere_s) begin
          nextState_s = DOOR;
        end else begin
          nextState_s = MOVE;
        end
      end
      DOOR: begin
        if (doorRetrig_s) begin
          nextDoorCnt_s = '0;
        end else if (doorCnt_r == DOOR_LAST) begin
          nextDoorCnt_s = '0;
          nextState_s   = IDLE;
        end else begin
          nextDoorCnt_s = doorCnt_r + DOOR_ONE;
        end
      end
      default: begin
        nextState_s = IDLE;
      end
    endcase
  end

  // Next values of status flags and clear pulses.
  always_comb begin
    nextMoving_s    = (nextState_s == MOVE);
    nextDoorOpen_s  = (nextState_s == DOOR);
    nextClrUp_s     = '0;
    nextClrDown_s   = '0;
    nextClrInside_s = '0;
    if ((nextState_s == DOOR) && (state_r != DOOR)) begin
      nextClrUp_s     = svcUp_s;
      nextClrDown_s   = svcDown_s;
      nextClrInside_s = svcInside_s;
    end else if ((state_r == DOOR) && doorRetrig_s) begin
      nextClrUp_s     = freshUp_s;
      nextClrDown_s   = freshDown_s;
      nextClrInside_s = freshInside_s;
    end else begin
      nextClrUp_s     = '0;
      nextClrDown_s   = '0;
      nextClrInside_s = '0;
    end
  end

endmodule
